lsu_mem_engine: RTL and testbench

Execution side of the LSU stage. It consumes the registered EXU→LSU payload and `lsu_valid`, and returns `lsu_ready`. For loads and stores it acts as initiator on a request/response data-memory bus, then extends or aligns the load data. It presents the writeback payload to the WBU with a valid/allow-in handshake and honours `pipeline_flush`.

---
 rtl/lsu_mem_engine.sv | 195 +++++++++++++++++++
 tb/tb_lsu_mem_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_engine.sv
// lsu_mem_engine
//   Execution side of the LSU stage. It takes the registered EXU->LSU payload,
//   runs one load or store on a request/response data-memory bus, extends or
//   aligns the returned load data, and presents the writeback payload to the
//   WBU through a valid/allow-in handshake. Non-memory ops pass through with no
//   added latency. pipeline_flush kills the op in flight.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   lsu_valid/ready     stage handshake (ready = op completes this cycle)
//   i_*                 EXU payload (control, address/ALU result, store data)
//   mem_req_*           request channel: valid/ready, addr, wen, wdata, wmask
//   mem_resp_*          response channel: valid/ready, rdata (8-byte aligned)
//   wbu_valid/allow_in  writeback handshake
//   o_*                 writeback payload (o_wdata = load result or ALU result)
//   pipeline_flush      kill current op
module lsu_mem_engine #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              i_MemWr,
   input  logic [2:0]        i_MemOP,
   input  logic [XLEN-1:0]   i_R_rs2,
   input  logic [XLEN-1:0]   i_ALUres,
   input  logic [1:0]        i_RegSrc,
   input  logic              i_RegWr,
   input  logic              i_isecall,
   input  logic              i_ismret,
   input  logic              i_iscsr,
   input  logic [INST_W-1:0] i_inst,
   input  logic [XLEN-1:0]   i_pc,
   input  logic [XLEN-1:0]   i_R_rs1,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_wen,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_rdata,
   output logic              mem_resp_ready,
   output logic              wbu_valid,
   input  logic              wbu_allow_in,
   output logic [XLEN-1:0]   o_wdata,
   output logic [1:0]        o_RegSrc,
   output logic              o_RegWr,
   output logic              o_isecall,
   output logic              o_ismret,
   output logic              o_iscsr,
   output logic [INST_W-1:0] o_inst,
   output logic [XLEN-1:0]   o_pc,
   output logic [XLEN-1:0]   o_R_rs1,
   input  logic              pipeline_flush
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [XLEN-1:0]   load_buf;
   logic              load_cap;
   logic              need_mem;
   logic              is_load;
   logic [5:0]        byte_sh;
   logic [7:0]        mask_base;
   logic [14:0]       mask_full;
   logic [XLEN-1:0]   rdata_sh;
   logic [XLEN-1:0]   load_ext;

   assign is_load  = (i_RegSrc == 2'b01);
   assign need_mem = i_MemWr | is_load;
   assign byte_sh  = {i_ALUres[2:0], 3'b000};

   // Request fields derive straight from the registered payload, which the
   // upstream stage holds until lsu_ready, so they are stable throughout REQ.
   assign mem_addr  = {i_ALUres[XLEN-1:3], 3'b000};
   assign mem_wen   = i_MemWr;
   assign mem_wdata = i_R_rs2 << byte_sh;

   always_comb begin
      mask_base = '0;
      case (i_MemOP[1:0])
         2'b00:   mask_base = 8'h01;
         2'b01:   mask_base = 8'h03;
         2'b10:   mask_base = 8'h0F;
         default: mask_base = 8'hFF;
      endcase
   end

   // Widen before shifting; the upper bits of a boundary-crossing access
   // simply fall off.
   assign mask_full = {7'b0, mask_base} << i_ALUres[2:0];
   assign mem_wmask = mask_full[7:0];

   assign rdata_sh = mem_resp_rdata >> byte_sh;

   always_comb begin
      load_ext = rdata_sh;
      case (i_MemOP)
         3'b000:  load_ext = {{(XLEN-8){rdata_sh[7]}},   rdata_sh[7:0]};
         3'b001:  load_ext = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
         3'b010:  load_ext = {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
         3'b100:  load_ext = {{(XLEN-8){1'b0}},          rdata_sh[7:0]};
         3'b101:  load_ext = {{(XLEN-16){1'b0}},         rdata_sh[15:0]};
         3'b110:  load_ext = {{(XLEN-32){1'b0}},         rdata_sh[31:0]};
         default: load_ext = rdata_sh;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         load_buf <= '0;
      end else begin
         state <= state_nxt;
         if (load_cap)
            load_buf <= load_ext;
      end
   end

   always_comb begin
      state_nxt      = state;
      load_cap       = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      wbu_valid      = 1'b0;
      lsu_ready      = 1'b0;
      case (state)
         S_IDLE: begin
            // The pass-through path is purely combinational; qualify it with
            // rst so outputs sit at their reset values while reset is held.
            if (rst && lsu_valid && !need_mem) begin
               wbu_valid = 1'b1;
               lsu_ready = wbu_allow_in;
            end else if (lsu_valid && need_mem && !pipeline_flush) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready)
               state_nxt = pipeline_flush ? S_DRAIN : S_RESP;
            else if (pipeline_flush)
               state_nxt = S_IDLE;
         end
         S_RESP: begin
            mem_resp_ready = 1'b1;
            if (pipeline_flush) begin
               state_nxt = S_DRAIN;
            end else if (mem_resp_valid) begin
               load_cap  = 1'b1;
               state_nxt = S_HOLD;
            end
         end
         S_DRAIN: begin
            mem_resp_ready = 1'b1;
            if (mem_resp_valid)
               state_nxt = S_IDLE;
         end
         S_HOLD: begin
            if (pipeline_flush) begin
               state_nxt = S_IDLE;
            end else begin
               wbu_valid = 1'b1;
               lsu_ready = wbu_allow_in;
               if (wbu_allow_in)
                  state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stores write back i_ALUres; the memory response is only an ack for them.
   assign o_wdata   = is_load ? load_buf : i_ALUres;
   assign o_RegSrc  = i_RegSrc;
   assign o_RegWr   = i_RegWr;
   assign o_isecall = i_isecall;
   assign o_ismret  = i_ismret;
   assign o_iscsr   = i_iscsr;
   assign o_inst    = i_inst;
   assign o_pc      = i_pc;
   assign o_R_rs1   = i_R_rs1;

endmodule

// File: tb/tb_lsu_mem_engine.sv
// tb_lsu_mem_engine
//   Directed-vector bench for lsu_mem_engine. Inputs change 2 time units
//   after each rising edge, outputs are compared 1 unit later.
module tb_lsu_mem_engine;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned INST_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              lsu_valid, lsu_ready;
   logic              i_MemWr;
   logic [2:0]        i_MemOP;
   logic [XLEN-1:0]   i_R_rs2, i_ALUres, i_pc, i_R_rs1;
   logic [1:0]        i_RegSrc;
   logic              i_RegWr, i_isecall, i_ismret, i_iscsr;
   logic [INST_W-1:0] i_inst;
   logic              mem_req_valid, mem_req_ready;
   logic [XLEN-1:0]   mem_addr, mem_wdata, mem_resp_rdata;
   logic              mem_wen;
   logic [7:0]        mem_wmask;
   logic              mem_resp_valid, mem_resp_ready;
   logic              wbu_valid, wbu_allow_in;
   logic [XLEN-1:0]   o_wdata, o_pc, o_R_rs1;
   logic [1:0]        o_RegSrc;
   logic              o_RegWr, o_isecall, o_ismret, o_iscsr;
   logic [INST_W-1:0] o_inst;
   logic              pipeline_flush;

   int unsigned checks = 0;
   int unsigned errors = 0;

   lsu_mem_engine #(.XLEN(XLEN), .INST_W(INST_W)) dut (
      .clk(clk), .rst(rst),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .i_MemWr(i_MemWr), .i_MemOP(i_MemOP), .i_R_rs2(i_R_rs2),
      .i_ALUres(i_ALUres), .i_RegSrc(i_RegSrc), .i_RegWr(i_RegWr),
      .i_isecall(i_isecall), .i_ismret(i_ismret), .i_iscsr(i_iscsr),
      .i_inst(i_inst), .i_pc(i_pc), .i_R_rs1(i_R_rs1),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .mem_resp_ready(mem_resp_ready),
      .wbu_valid(wbu_valid), .wbu_allow_in(wbu_allow_in),
      .o_wdata(o_wdata), .o_RegSrc(o_RegSrc), .o_RegWr(o_RegWr),
      .o_isecall(o_isecall), .o_ismret(o_ismret), .o_iscsr(o_iscsr),
      .o_inst(o_inst), .o_pc(o_pc), .o_R_rs1(o_R_rs1),
      .pipeline_flush(pipeline_flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_op(input logic wr, input logic [2:0] op, input logic [63:0] rs2,
                         input logic [63:0] alu, input logic [1:0] src);
      lsu_valid = 1'b1;
      i_MemWr   = wr;
      i_MemOP   = op;
      i_R_rs2   = rs2;
      i_ALUres  = alu;
      i_RegSrc  = src;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".req_valid"},  {63'b0, mem_req_valid},  64'd0);
      check({tag, ".resp_ready"}, {63'b0, mem_resp_ready}, 64'd0);
      check({tag, ".wbu_valid"},  {63'b0, wbu_valid},      64'd0);
      check({tag, ".lsu_ready"},  {63'b0, lsu_ready},      64'd0);
   endtask

   // Load with immediate ready/response: REQ, RESP, HOLD on the three edges
   // following lsu_valid.
   task automatic do_load(input string tag, input logic [2:0] op, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
      set_op(1'b0, op, 64'd0, addr, 2'b01);
      #1 check({tag, ".idle_wbv"}, {63'b0, wbu_valid}, 64'd0);
      tick();
      #1 check({tag, ".req"}, {63'b0, mem_req_valid}, 64'd1);
      check({tag, ".addr"}, mem_addr, {addr[63:3], 3'b000});
      check({tag, ".wen"}, {63'b0, mem_wen}, 64'd0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      #1 check({tag, ".resp_rdy"}, {63'b0, mem_resp_ready}, 64'd1);
      check({tag, ".resp_wbv"}, {63'b0, wbu_valid}, 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      wbu_allow_in   = 1'b1;
      #1 check({tag, ".wbv"}, {63'b0, wbu_valid}, 64'd1);
      check({tag, ".wdata"}, o_wdata, exp);
      check({tag, ".lsu_rdy"}, {63'b0, lsu_ready}, 64'd1);
      tick();
      wbu_allow_in = 1'b0;
      lsu_valid    = 1'b0;
      #1 check_idle_outputs({tag, ".done"});
   endtask

   initial begin
      rst = 1'b0;
      lsu_valid = 1'b0; i_MemWr = 1'b0; i_MemOP = '0; i_R_rs2 = '0; i_ALUres = '0;
      i_RegSrc = '0; i_RegWr = 1'b1; i_isecall = 1'b0; i_ismret = 1'b1; i_iscsr = 1'b0;
      i_inst = 32'h0000_3003; i_pc = 64'h8000_0100; i_R_rs1 = 64'h1234;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      wbu_allow_in = 1'b0; pipeline_flush = 1'b0;
      #3 check_idle_outputs("reset");
      tick();
      rst = 1'b1;
      tick();

      // ld, response two cycles after accept, WBU stalls one cycle in HOLD
      set_op(1'b0, 3'b011, 64'd0, 64'h8000_0008, 2'b01);
      tick();
      #1 check("ld.req", {63'b0, mem_req_valid}, 64'd1);
      check("ld.addr", mem_addr, 64'h8000_0008);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1 check("ld.req_drop", {63'b0, mem_req_valid}, 64'd0);
      check("ld.resp_rdy", {63'b0, mem_resp_ready}, 64'd1);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'h1122_3344_5566_7788;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      #1 check("ld.wbv", {63'b0, wbu_valid}, 64'd1);
      check("ld.wdata", o_wdata, 64'h1122_3344_5566_7788);
      check("ld.stall_rdy", {63'b0, lsu_ready}, 64'd0);
      check("ld.pc_fwd", o_pc, 64'h8000_0100);
      check("ld.inst_fwd", {32'b0, o_inst}, 64'h3003);
      check("ld.regsrc_fwd", {62'b0, o_RegSrc}, 64'd1);
      tick();
      wbu_allow_in = 1'b1;
      #1 check("ld.hold_wbv", {63'b0, wbu_valid}, 64'd1);
      check("ld.lsu_rdy", {63'b0, lsu_ready}, 64'd1);
      tick();
      wbu_allow_in = 1'b0;
      lsu_valid    = 1'b0;
      #1 check_idle_outputs("ld.done");

      // Extension variants
      do_load("lb",  3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      do_load("lbu", 3'b100, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
      do_load("lh",  3'b001, 64'h8000_0002, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_8000);
      do_load("lhu", 3'b101, 64'h8000_0002, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_8000);
      do_load("lw",  3'b010, 64'h8000_0004, 64'hCAFE_BABE_0000_0000, 64'hFFFF_FFFF_CAFE_BABE);
      do_load("lwu", 3'b110, 64'h8000_0004, 64'hCAFE_BABE_0000_0000, 64'h0000_0000_CAFE_BABE);

      // sw, request held off 5 cycles
      set_op(1'b1, 3'b010, 64'hDEAD_BEEF, 64'h8000_0004, 2'b00);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1 check("sw.req", {63'b0, mem_req_valid}, 64'd1);
         check("sw.wen", {63'b0, mem_wen}, 64'd1);
         check("sw.mask", {56'b0, mem_wmask}, 64'hF0);
         check("sw.wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
         check("sw.addr", mem_addr, 64'h8000_0000);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      #1 check("sw.wbv", {63'b0, wbu_valid}, 64'd1);
      check("sw.wdata_wb", o_wdata, 64'h8000_0004);
      wbu_allow_in = 1'b1;
      #1 check("sw.lsu_rdy", {63'b0, lsu_ready}, 64'd1);
      tick();
      wbu_allow_in = 1'b0;
      lsu_valid    = 1'b0;

      // sh at byte 7 crosses the boundary: truncated mask; then flush in REQ
      set_op(1'b1, 3'b001, 64'h0000_0000_0000_ABCD, 64'h8000_0007, 2'b00);
      tick();
      #1 check("sh7.mask", {56'b0, mem_wmask}, 64'h80);
      check("sh7.wdata", mem_wdata, 64'hCD00_0000_0000_0000);
      pipeline_flush = 1'b1;
      lsu_valid      = 1'b0;
      tick();
      pipeline_flush = 1'b0;
      #1 check_idle_outputs("reqflush");
      tick();
      #1 check("reqflush.stay", {63'b0, mem_req_valid}, 64'd0);

      // ALU op passes straight through
      set_op(1'b0, 3'b000, 64'd0, 64'h42, 2'b00);
      #1 check("alu.wbv_stall", {63'b0, wbu_valid}, 64'd1);
      check("alu.rdy_stall", {63'b0, lsu_ready}, 64'd0);
      wbu_allow_in = 1'b1;
      #1 check("alu.wdata", o_wdata, 64'h42);
      check("alu.lsu_rdy", {63'b0, lsu_ready}, 64'd1);
      tick();
      #1 check("alu.no_req", {63'b0, mem_req_valid}, 64'd0);
      lsu_valid    = 1'b0;
      wbu_allow_in = 1'b0;

      // Flush in RESP, response 3 cycles later is drained
      set_op(1'b0, 3'b011, 64'd0, 64'h10, 2'b01);
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      pipeline_flush = 1'b1;
      lsu_valid      = 1'b0;
      tick();
      pipeline_flush = 1'b0;
      #1 check("drain.resp_rdy", {63'b0, mem_resp_ready}, 64'd1);
      check("drain.wbv", {63'b0, wbu_valid}, 64'd0);
      set_op(1'b0, 3'b011, 64'd0, 64'h20, 2'b01);
      tick();
      #1 check("drain.no_req", {63'b0, mem_req_valid}, 64'd0);
      lsu_valid = 1'b0;
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'hFFFF_0000_FFFF_0000;
      #1 check("drain.wbv_resp", {63'b0, wbu_valid}, 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      #1 check_idle_outputs("drain.idle");

      // Async reset during RESP
      set_op(1'b0, 3'b011, 64'd0, 64'h8000_0008, 2'b01);
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1 check("rst.resp_rdy", {63'b0, mem_resp_ready}, 64'd1);
      rst = 1'b0;
      #1 check_idle_outputs("rst.mid");
      lsu_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      do_load("ld2", 3'b011, 64'h8000_0010, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
